// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: CPU-side 8N1 UART transmitter fed by a small write FIFO.
//   clk, rst         : clock and synchronous active-high reset
//   wr_en, wr_data   : push one byte per asserted cycle
//   clr_ovf          : clear the sticky overflow flag
//   tx               : serial line, idle high, LSB first
//   busy             : a frame is on the line
//   full, empty      : FIFO status
//   level            : bytes waiting (excluding the frame in flight)
//   overflow         : sticky, set when a write hits a full FIFO
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 8,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             clr_ovf,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic             push, pop, last;

    always_comb begin
        push     = wr_en && !full_q;
        pop      = 1'b0;
        last     = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = empty_q;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: if (last) begin
                cnt_d   = '0;
                bit_d   = 3'd0;
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (last) begin
                cnt_d = '0;
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                end
            end
            default: if (last) begin
                // Chain straight into the next start bit when more data waits.
                cnt_d   = '0;
                pop     = !empty_q;
                shift_d = empty_q ? shift_q : mem[rd_ptr_q];
                state_d = empty_q ? IDLE : START;
                tx_d    = empty_q;
            end
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + LVL_W'(push) - LVL_W'(pop);
        full_d   = count_d == LVL_W'(FIFO_DEPTH);
        empty_d  = count_d == '0;
        // A dropped write beats a simultaneous clear.
        ovf_d    = (wr_en && full_q) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = state_q != IDLE;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = count_q;
    assign overflow = ovf_q;
endmodule
